// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: CPU run/step/pace controller with MMIO data memory, LED register and run counter.
module cpu_run_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DMEM_DEPTH = 16,
    parameter int N_LED      = 4,
    parameter int LED_ADDR   = 1,
    parameter int TICK_DIV   = 50000000,
    parameter int RST_HOLD   = 4
) (
    input  logic              CLK100MHZ,
    input  logic              RST,
    input  logic [1:0]        RUN_MODE,
    input  logic              STEP_BTN,
    input  logic              LED_MODE,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_READ_WRN,
    output logic [DATA_W-1:0] MEM_RDATA,
    output logic              CPU_RST_N,
    output logic              CPU_HALT,
    output logic [N_LED-1:0]  LED_OUT,
    output logic [31:0]       RUN_CNT
);
    localparam int MAW = DMEM_DEPTH > 1 ? $clog2(DMEM_DEPTH) : 1;
    localparam int LAW = $clog2(N_LED);

    typedef enum logic [2:0] {HOLD, RUN, PACE_WAIT, PULSE, STEP_WAIT, HALTED} state_t;
    state_t state, state_nxt, tgt;

    logic [DATA_W-1:0] mem [DMEM_DEPTH];
    logic [N_LED-1:0]  led, led_nxt;
    logic [31:0]       hold_cnt, tick_cnt;
    logic [2:0]        sync;
    logic              in_range, wr_ok, step_ev;
    logic [MAW-1:0]    idx;

    assign in_range  = MEM_ADDR < ADDR_W'(DMEM_DEPTH);
    assign idx       = MEM_ADDR[MAW-1:0];
    assign MEM_RDATA = in_range ? mem[idx] : '0;
    assign wr_ok     = !MEM_READ_WRN && CPU_RST_N && !CPU_HALT;
    assign led_nxt   = (wr_ok && MEM_ADDR == ADDR_W'(LED_ADDR)) ? MEM_WDATA[N_LED-1:0] : led;
    // sync[1] is the synchronised button, sync[2] its previous value for edge detection
    assign step_ev   = sync[1] && !sync[2];

    always_comb begin
        tgt = HALTED;
        case (RUN_MODE)
            2'b00:   tgt = RUN;
            2'b01:   tgt = PACE_WAIT;
            2'b10:   tgt = STEP_WAIT;
            default: tgt = HALTED;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD:      if (hold_cnt == 32'(RST_HOLD - 1)) state_nxt = tgt;
            PACE_WAIT: state_nxt = tgt != PACE_WAIT ? tgt : tick_cnt == 32'(TICK_DIV - 2) ? PULSE : PACE_WAIT;
            STEP_WAIT: state_nxt = tgt != STEP_WAIT ? tgt : step_ev ? PULSE : STEP_WAIT;
            default:   state_nxt = tgt;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            tick_cnt  <= '0;
            sync      <= '0;
            led       <= '0;
            LED_OUT   <= '0;
            RUN_CNT   <= '0;
            CPU_RST_N <= 1'b0;
            CPU_HALT  <= 1'b1;
            for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= state == HOLD ? hold_cnt + 1 : '0;
            tick_cnt  <= (state == PACE_WAIT && state_nxt == PACE_WAIT) ? tick_cnt + 1 : '0;
            sync      <= {sync[1:0], STEP_BTN};
            led       <= led_nxt;
            LED_OUT   <= LED_MODE ? led_nxt : N_LED'(1) << led_nxt[LAW-1:0];
            CPU_RST_N <= state_nxt != HOLD;
            CPU_HALT  <= !(state_nxt == RUN || state_nxt == PULSE);
            if (CPU_RST_N && !CPU_HALT && RUN_CNT != '1) RUN_CNT <= RUN_CNT + 1;
            if (wr_ok && in_range) mem[idx] <= MEM_WDATA;
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scenario tasks with a behavioural memory/LED model and arithmetic timing expectations.
module tb_cpu_run_ctrl;
    logic        clk = 0;
    logic        rst = 1;
    logic [1:0]  run_mode = 0;
    logic        step_btn = 0, led_mode = 0, mem_read_wrn = 1;
    logic [31:0] mem_addr = 0, mem_wdata = 0;
    logic [31:0] mem_rdata, run_cnt;
    logic        cpu_rst_n, cpu_halt;
    logic [3:0]  led_out;

    int total = 0, bad = 0;
    logic [31:0] mdl_mem [16];
    logic [3:0]  mdl_led;

    cpu_run_ctrl #(.TICK_DIV(4), .RST_HOLD(4)) dut (
        .CLK100MHZ(clk), .RST(rst), .RUN_MODE(run_mode), .STEP_BTN(step_btn),
        .LED_MODE(led_mode), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
        .MEM_READ_WRN(mem_read_wrn), .MEM_RDATA(mem_rdata), .CPU_RST_N(cpu_rst_n),
        .CPU_HALT(cpu_halt), .LED_OUT(led_out), .RUN_CNT(run_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] led_exp(input logic mode, input logic [3:0] v);
        logic [3:0] one;
        one = 4'd1;
        return mode ? v : one << v[1:0];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 0;
        mdl_led = 0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL reset_rstn got %b want 0", cpu_rst_n); end
        total++; if (cpu_halt !== 1'b1) begin bad++; $display("FAIL reset_halt got %b want 1", cpu_halt); end
        total++; if (led_out !== 4'h0) begin bad++; $display("FAIL reset_led got %h want 0", led_out); end
        total++; if (run_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", run_cnt); end
        total++; if (mem_rdata !== 32'd0) begin bad++; $display("FAIL reset_mem got %h want 0", mem_rdata); end
        clear_model();
        rst = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (cpu_rst_n !== (i == 4)) begin bad++; $display("FAIL hold_rstn edge %0d got %b want %b", i, cpu_rst_n, i == 4); end
        end
        total++; if (cpu_halt !== 1'b0) begin bad++; $display("FAIL run_halt got %b want 0", cpu_halt); end
        repeat (10) tick();
        total++; if (run_cnt !== 32'd10) begin bad++; $display("FAIL run_cnt10 got %0d want 10", run_cnt); end
    endtask

    task automatic test_led_write();
        mem_addr = 1; mem_wdata = 32'h2; mem_read_wrn = 0; led_mode = 0;
        tick();
        mem_read_wrn = 1;
        mdl_mem[1] = 32'h2; mdl_led = 4'h2;
        total++; if (led_out !== 4'b0100) begin bad++; $display("FAIL led_onehot got %b want 0100", led_out); end
        #1;
        total++; if (mem_rdata !== 32'h2) begin bad++; $display("FAIL led_addr_read got %h want 2", mem_rdata); end
        led_mode = 1;
        tick();
        total++; if (led_out !== 4'b0010) begin bad++; $display("FAIL led_direct got %b want 0010", led_out); end
    endtask

    task automatic test_out_of_range();
        mem_addr = 16; mem_wdata = 32'hDEAD; mem_read_wrn = 0;
        tick();
        mem_read_wrn = 1;
        #1;
        total++; if (mem_rdata !== 32'd0) begin bad++; $display("FAIL oor_read got %h want 0", mem_rdata); end
        mem_addr = 0;
        #1;
        total++; if (mem_rdata !== mdl_mem[0]) begin bad++; $display("FAIL oor_addr0 got %h want %h", mem_rdata, mdl_mem[0]); end
        total++; if (led_out !== led_exp(led_mode, mdl_led)) begin bad++; $display("FAIL oor_led got %b want %b", led_out, led_exp(led_mode, mdl_led)); end
    endtask

    task automatic test_random_mem();
        int a;
        logic [31:0] d;
        logic w;
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(0, 19));
            d = $urandom;
            w = $urandom_range(0, 1) == 1;
            mem_addr = 32'(a); mem_wdata = d; mem_read_wrn = !w; led_mode = $urandom_range(0, 1) == 1;
            #1;
            total++; if (mem_rdata !== (a < 16 ? mdl_mem[a] : 32'd0)) begin bad++; $display("FAIL rnd_read addr %0d got %h want %h", a, mem_rdata, a < 16 ? mdl_mem[a] : 32'd0); end
            tick();
            if (w && a < 16) mdl_mem[a] = d;
            if (w && a == 1) mdl_led = d[3:0];
            total++; if (led_out !== led_exp(led_mode, mdl_led)) begin bad++; $display("FAIL rnd_led iter %0d got %b want %b", n, led_out, led_exp(led_mode, mdl_led)); end
        end
        mem_read_wrn = 1;
    endtask

    task automatic test_paced();
        logic [31:0] c0;
        int lows = 0;
        run_mode = 2'b01;
        tick();
        c0 = run_cnt;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) begin mem_addr = 2; mem_wdata = 32'hBEEF; mem_read_wrn = 0; end
            if (i == 2) mem_read_wrn = 1;
            tick();
            total++; if (cpu_halt !== (i % 4 != 3)) begin bad++; $display("FAIL pace_halt cycle %0d got %b want %b", i, cpu_halt, i % 4 != 3); end
            if (!cpu_halt) lows++;
        end
        total++; if (lows != 5) begin bad++; $display("FAIL pace_pulses got %0d want 5", lows); end
        total++; if (run_cnt - c0 !== 32'd5) begin bad++; $display("FAIL pace_cnt got %0d want 5", run_cnt - c0); end
        mem_addr = 2;
        #1;
        total++; if (mem_rdata !== mdl_mem[2]) begin bad++; $display("FAIL pace_drop got %h want %h", mem_rdata, mdl_mem[2]); end
    endtask

    task automatic test_step();
        logic [31:0] c0;
        int lows;
        run_mode = 2'b10;
        tick();
        total++; if (cpu_halt !== 1'b1) begin bad++; $display("FAIL step_enter got %b want 1", cpu_halt); end
        c0 = run_cnt;
        for (int p = 0; p < 3; p++) begin
            lows = 0;
            for (int j = 0; j < 10; j++) begin
                step_btn = j < 2;
                tick();
                if (!cpu_halt) lows++;
            end
            total++; if (lows != 1) begin bad++; $display("FAIL step_pulse %0d got %0d want 1", p, lows); end
        end
        total++; if (run_cnt - c0 !== 32'd3) begin bad++; $display("FAIL step_cnt got %0d want 3", run_cnt - c0); end
        lows = 0;
        for (int j = 0; j < 20; j++) begin
            step_btn = j < 15;
            tick();
            if (!cpu_halt) lows++;
        end
        total++; if (lows != 1) begin bad++; $display("FAIL step_held got %0d want 1", lows); end
    endtask

    task automatic test_halted();
        logic [31:0] c0;
        run_mode = 2'b11;
        tick();
        c0 = run_cnt;
        for (int j = 0; j < 8; j++) begin
            tick();
            total++; if (cpu_halt !== 1'b1) begin bad++; $display("FAIL halted_halt cycle %0d got %b want 1", j, cpu_halt); end
        end
        total++; if (run_cnt !== c0) begin bad++; $display("FAIL halted_cnt got %0d want %0d", run_cnt, c0); end
        run_mode = 2'b00;
        tick();
        total++; if (cpu_halt !== 1'b0) begin bad++; $display("FAIL resume_halt got %b want 0", cpu_halt); end
    endtask

    task automatic test_reset_mid_pulse();
        bit found = 0;
        run_mode = 2'b01;
        for (int j = 0; j < 20 && !found; j++) begin
            tick();
            if (!cpu_halt) found = 1;
        end
        total++; if (!found) begin bad++; $display("FAIL pulse_wait got timeout want pulse"); end
        mem_addr = 3; mem_wdata = 32'h1234; mem_read_wrn = 0;
        #2;
        rst = 1;
        #1;
        clear_model();
        total++; if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL midrst_rstn got %b want 0", cpu_rst_n); end
        total++; if (cpu_halt !== 1'b1) begin bad++; $display("FAIL midrst_halt got %b want 1", cpu_halt); end
        total++; if (led_out !== 4'h0) begin bad++; $display("FAIL midrst_led got %h want 0", led_out); end
        total++; if (run_cnt !== 32'd0) begin bad++; $display("FAIL midrst_cnt got %0d want 0", run_cnt); end
        total++; if (mem_rdata !== 32'd0) begin bad++; $display("FAIL midrst_mem3 got %h want 0", mem_rdata); end
        mem_addr = 1;
        #1;
        total++; if (mem_rdata !== 32'd0) begin bad++; $display("FAIL midrst_mem1 got %h want 0", mem_rdata); end
        tick();
        rst = 0; mem_read_wrn = 1; mem_addr = 3;
        repeat (4) tick();
        total++; if (cpu_rst_n !== 1'b1 || cpu_halt !== 1'b1) begin bad++; $display("FAIL midrst_resume got rstn=%b halt=%b want rstn=1 halt=1", cpu_rst_n, cpu_halt); end
        total++; if (mem_rdata !== mdl_mem[3]) begin bad++; $display("FAIL midrst_after got %h want %h", mem_rdata, mdl_mem[3]); end
    endtask

    initial begin
        test_reset();
        test_led_write();
        test_out_of_range();
        test_random_mem();
        test_paced();
        test_step();
        test_halted();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
